trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/tvec width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- StallM  in  1  memory stage stalled.
- IllegalInstrFaultM, BreakpointFaultM, EcallFaultM  in  1 each  exception flags from privileged decode.
- mretM, sretM, wfiM  in  1 each  return and wait-for-interrupt instructions from privileged decode.
- PrivilegeModeW  in  2  current privilege: 00 = U, 01 = S, 11 = M.
- STATUS_MIE, STATUS_SIE  in  1 each  global interrupt enables.
- MIP_REGW, MIE_REGW, MIDELEG_REGW  in  12 each  interrupt pending, enable and delegation.
- MEDELEG_REGW  in  16  exception delegation.
- MTVEC_REGW, STVEC_REGW  in  XLEN each  trap vector CSRs.
- TrapM  out  1  trap taken this cycle (flush).
- InterruptM  out  1  taken trap is an interrupt.
- CauseM  out  4  cause code.
- TrapToSM  out  1  trap handled in S mode.
- TrapVectorM  out  XLEN  redirect PC.
- RetM  out  1  mret/sret commits.
- WFIStallM  out  1  pipeline held in WFI.

Function
REQ-003 SHALL register MIP_REGW & MIE_REGW every cycle into PendingIntsQ; all interrupt decisions use PendingIntsQ, giving 1-cycle latency from the CSR inputs.
REQ-004 SHALL treat interrupt bit i as enabled when either condition holds:
- not delegated and (PrivilegeModeW != M or STATUS_MIE);
- delegated (MIDELEG_REGW[i]) and PrivilegeModeW != M and (PrivilegeModeW == U or STATUS_SIE).
REQ-005 SHALL pick among enabled interrupts with fixed priority 11 > 3 > 7 > 9 > 1 > 5; CauseM = the selected bit index.
REQ-006 SHALL pick among exceptions with priority breakpoint (cause 3) > illegal (cause 2) > ecall (cause 8 + PrivilegeModeW, i.e. 8, 9 or 11).
REQ-007 SHALL give interrupts priority over all exceptions in the same cycle.
REQ-008 SHALL assert TrapM = (any exception, or any enabled interrupt in RUN or WFI state) & ~StallM & ~reset.
REQ-009 SHALL set TrapToSM:
- interrupt: MIDELEG bit set and PrivilegeModeW != M;
- exception: MEDELEG_REGW[CauseM] set and PrivilegeModeW != M.
REQ-010 SHALL compute the vector base from the trap tvec: STVEC_REGW if TrapToSM else MTVEC_REGW, with bits [1:0] forced to 00.
REQ-011 SHALL set TrapVectorM = base by default; vectored mode is defined in Configuration.
REQ-012 SHALL drive RetM = (mretM | sretM) & ~TrapM & ~StallM; a trap in the same cycle suppresses the return.
REQ-013 SHALL implement FSM states RUN and WFI:
- RUN -> WFI when wfiM & ~StallM & ~TrapM & no enabled-or-disabled pending bit (PendingIntsQ == 0);
- WFI -> RUN when PendingIntsQ != 0 (regardless of global enables), or when TrapM.
REQ-014 SHALL assert WFIStallM only in state WFI; WFI exit deasserts WFIStallM the following cycle.
REQ-015 SHALL, if wfiM arrives while PendingIntsQ != 0, treat it as a nop and stay in RUN.
REQ-016 SHALL drive InterruptM, CauseM, TrapToSM and TrapVectorM to 0 whenever TrapM = 0.

Reset
REQ-017 SHALL, on a synchronous reset, set the FSM to RUN and PendingIntsQ to 0, and force all outputs to 0 in the reset cycle.
REQ-018 SHALL abandon a WFI in progress on reset, returning to RUN with WFIStallM = 0 the next cycle.

Configuration
REQ-019 SHALL, when TRAP_VECTORED_EN is defined, set TrapVectorM = base + 4*CauseM for interrupts whose selected tvec[1:0] == 01.
REQ-020 SHALL, without TRAP_VECTORED_EN, ignore tvec[1:0] and always use the base.

Verification
REQ-021 SHALL cover these directed scenarios:
- Priority: M mode, MIE = 1, MIP = MIE = 0x888, IllegalInstrFaultM = 1 (one cycle after the MIP set) -> TrapM = 1, InterruptM = 1, CauseM = 11, TrapToSM = 0.
- Ecall delegation: U mode, EcallFaultM = 1, MEDELEG[8] = 1, STVEC = 0x8000_0101 -> CauseM = 8, TrapToSM = 1, TrapVectorM = 0x8000_0100.
- Vectored: TRAP_VECTORED_EN defined, M mode, MIE = 1, MTVEC = 0x1001, MTI pending and enabled -> CauseM = 7, TrapVectorM = 0x101C; without the macro -> 0x1000.
- WFI: wfiM with PendingIntsQ = 0 -> WFIStallM = 1 next cycle; MIP[7] = MIE[7] = 1 with STATUS_MIE = 0 in M mode -> RUN two cycles later, TrapM = 0.
- Return conflict: mretM = 1 with enabled MSI pending -> TrapM = 1, CauseM = 3, RetM = 0.
- Reset in WFI: reset pulsed while WFIStallM = 1 -> all outputs 0, state RUN after release.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap sequencer: picks the highest-priority interrupt or exception each cycle,
// computes cause, delegation and redirect vector, gates mret/sret, and holds the
// pipeline in WFI until an interrupt becomes pending.
// Optional feature: define TRAP_VECTORED_EN to enable vectored interrupt dispatch
// (tvec[1:0] == 01 -> base + 4*cause for interrupts).
module trap_sequencer #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            IllegalInstrFaultM,
  input  logic            BreakpointFaultM,
  input  logic            EcallFaultM,
  input  logic            mretM,
  input  logic            sretM,
  input  logic            wfiM,
  input  logic [1:0]      PrivilegeModeW,
  input  logic            STATUS_MIE,
  input  logic            STATUS_SIE,
  input  logic [11:0]     MIP_REGW,
  input  logic [11:0]     MIE_REGW,
  input  logic [11:0]     MIDELEG_REGW,
  input  logic [15:0]     MEDELEG_REGW,
  input  logic [XLEN-1:0] MTVEC_REGW,
  input  logic [XLEN-1:0] STVEC_REGW,
  output logic            TrapM,
  output logic            InterruptM,
  output logic [3:0]      CauseM,
  output logic            TrapToSM,
  output logic [XLEN-1:0] TrapVectorM,
  output logic            RetM,
  output logic            WFIStallM
);

  typedef enum logic [0:0] {StRun, StWfi} state_e;

  state_e      r_state;
  logic [11:0] r_pending_ints;

  logic        w_not_m;
  logic [11:0] w_int_en;
  logic        w_any_int;
  logic [3:0]  w_int_cause;
  logic        w_any_exc;
  logic [3:0]  w_exc_cause;
  logic [3:0]  w_cause;
  logic        w_trap;
  logic        w_to_s;
  logic [XLEN-1:0] w_tvec;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vector;

  // Register the pending-and-enabled interrupt set; all decisions use this copy.
  always_ff @(posedge clk) begin
    if (reset) r_pending_ints <= '0;
    else       r_pending_ints <= MIP_REGW & MIE_REGW;
  end

  assign w_not_m  = (PrivilegeModeW != 2'b11);
  assign w_int_en = r_pending_ints &
                    ((~MIDELEG_REGW & {12{w_not_m | STATUS_MIE}}) |
                     (MIDELEG_REGW & {12{w_not_m & ((PrivilegeModeW == 2'b00) | STATUS_SIE)}}));
  // Only the six standard S/M interrupt sources can be taken.
  assign w_any_int = |(w_int_en & 12'hAAA);

  // Fixed interrupt and exception priority encoders.
  always_comb begin
    w_int_cause = 4'd0;
    if      (w_int_en[11]) w_int_cause = 4'd11;
    else if (w_int_en[3])  w_int_cause = 4'd3;
    else if (w_int_en[7])  w_int_cause = 4'd7;
    else if (w_int_en[9])  w_int_cause = 4'd9;
    else if (w_int_en[1])  w_int_cause = 4'd1;
    else if (w_int_en[5])  w_int_cause = 4'd5;

    w_any_exc   = BreakpointFaultM | IllegalInstrFaultM | EcallFaultM;
    w_exc_cause = 4'd0;
    if      (BreakpointFaultM)   w_exc_cause = 4'd3;
    else if (IllegalInstrFaultM) w_exc_cause = 4'd2;
    else if (EcallFaultM)        w_exc_cause = {2'b10, PrivilegeModeW};
  end

  assign w_trap  = (w_any_exc | w_any_int) & ~StallM & ~reset;
  assign w_cause = w_any_int ? w_int_cause : w_exc_cause;
  assign w_to_s  = w_not_m & (w_any_int ? MIDELEG_REGW[w_int_cause] : MEDELEG_REGW[w_exc_cause]);
  assign w_tvec  = w_to_s ? STVEC_REGW : MTVEC_REGW;
  assign w_base  = {w_tvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign w_vector = (w_any_int && (w_tvec[1:0] == 2'b01)) ?
                    w_base + {{(XLEN-6){1'b0}}, w_int_cause, 2'b00} : w_base;
`else
  logic w_unused_tvec_mode;
  assign w_unused_tvec_mode = ^w_tvec[1:0];
  assign w_vector = w_base;
`endif

  assign TrapM       = w_trap;
  assign InterruptM  = w_trap & w_any_int;
  assign CauseM      = w_trap ? w_cause : 4'd0;
  assign TrapToSM    = w_trap & w_to_s;
  assign TrapVectorM = w_trap ? w_vector : '0;
  assign RetM        = (mretM | sretM) & ~w_trap & ~StallM & ~reset;
  assign WFIStallM   = (r_state == StWfi) & ~reset;

  // WFI state machine; any pending bit wakes it, even if globally disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StRun;
    end else begin
      unique case (r_state)
        StRun: if (wfiM && !StallM && !w_trap && (r_pending_ints == 12'd0)) r_state <= StWfi;
        StWfi: if ((r_pending_ints != 12'd0) || w_trap) r_state <= StRun;
        default: r_state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized
// cycles compared against a behavioural model of the trap rules.
module tb_trap_sequencer;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            StallM;
  logic            IllegalInstrFaultM, BreakpointFaultM, EcallFaultM;
  logic            mretM, sretM, wfiM;
  logic [1:0]      PrivilegeModeW;
  logic            STATUS_MIE, STATUS_SIE;
  logic [11:0]     MIP_REGW, MIE_REGW, MIDELEG_REGW;
  logic [15:0]     MEDELEG_REGW;
  logic [XLEN-1:0] MTVEC_REGW, STVEC_REGW;
  logic            TrapM, InterruptM, TrapToSM, RetM, WFIStallM;
  logic [3:0]      CauseM;
  logic [XLEN-1:0] TrapVectorM;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: registered pending set and whether the core sleeps in WFI.
  logic [11:0] m_pend = '0, m_pend_n;
  bit          m_wfi = 1'b0, m_wfi_n;

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .StallM(StallM),
    .IllegalInstrFaultM(IllegalInstrFaultM), .BreakpointFaultM(BreakpointFaultM),
    .EcallFaultM(EcallFaultM), .mretM(mretM), .sretM(sretM), .wfiM(wfiM),
    .PrivilegeModeW(PrivilegeModeW), .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE),
    .MIP_REGW(MIP_REGW), .MIE_REGW(MIE_REGW), .MIDELEG_REGW(MIDELEG_REGW),
    .MEDELEG_REGW(MEDELEG_REGW), .MTVEC_REGW(MTVEC_REGW), .STVEC_REGW(STVEC_REGW),
    .TrapM(TrapM), .InterruptM(InterruptM), .CauseM(CauseM), .TrapToSM(TrapToSM),
    .TrapVectorM(TrapVectorM), .RetM(RetM), .WFIStallM(WFIStallM)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge, compare with the model, and prepare model next state.
  task automatic cyc_check();
    int          prio[6];
    bit          not_m, en, is_int, is_exc, trap, to_s;
    int          cause;
    logic [63:0] tvec, vec;
    prio = '{11, 3, 7, 9, 1, 5};
    @(negedge clk);
    #1;
    not_m  = (PrivilegeModeW != 2'd3);
    is_int = 1'b0;
    cause  = 0;
    for (int k = 0; k < 6; k++) begin
      int i;
      i  = prio[k];
      en = m_pend[i] && ((!MIDELEG_REGW[i] && (not_m || STATUS_MIE)) ||
                         (MIDELEG_REGW[i] && not_m && (PrivilegeModeW == 2'd0 || STATUS_SIE)));
      if (en && !is_int) begin
        is_int = 1'b1;
        cause  = i;
      end
    end
    is_exc = BreakpointFaultM || IllegalInstrFaultM || EcallFaultM;
    if (!is_int) begin
      if (BreakpointFaultM)        cause = 3;
      else if (IllegalInstrFaultM) cause = 2;
      else if (EcallFaultM)        cause = 8 + int'(PrivilegeModeW);
    end
    trap = (is_int || is_exc) && !StallM && !reset;
    to_s = not_m && (is_int ? MIDELEG_REGW[cause] : MEDELEG_REGW[cause]);
    tvec = to_s ? STVEC_REGW : MTVEC_REGW;
    vec  = tvec & ~64'h3;
`ifdef TRAP_VECTORED_EN
    if (is_int && tvec[1:0] == 2'b01) vec = vec + 64'(4 * cause);
`endif
    check_eq("TrapM", 64'(TrapM), 64'(trap));
    check_eq("InterruptM", 64'(InterruptM), 64'(trap && is_int));
    check_eq("CauseM", 64'(CauseM), trap ? 64'(cause) : 64'd0);
    check_eq("TrapToSM", 64'(TrapToSM), 64'(trap && to_s));
    check_eq("TrapVectorM", TrapVectorM, trap ? vec : 64'd0);
    check_eq("RetM", 64'(RetM), 64'((mretM || sretM) && !trap && !StallM && !reset));
    check_eq("WFIStallM", 64'(WFIStallM), 64'(m_wfi && !reset));
    if (reset) begin
      m_pend_n = '0;
      m_wfi_n  = 1'b0;
    end else begin
      m_pend_n = MIP_REGW & MIE_REGW;
      if (!m_wfi) m_wfi_n = wfiM && !StallM && !trap && (m_pend == 0);
      else        m_wfi_n = !((m_pend != 0) || trap);
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    m_pend = m_pend_n;
    m_wfi  = m_wfi_n;
    #1;
  endtask

  task automatic cyc();
    cyc_check();
    cyc_end();
  endtask

  task automatic clear_inputs();
    StallM = 0; IllegalInstrFaultM = 0; BreakpointFaultM = 0; EcallFaultM = 0;
    mretM = 0; sretM = 0; wfiM = 0; PrivilegeModeW = 2'd3; STATUS_MIE = 0; STATUS_SIE = 0;
    MIP_REGW = 0; MIE_REGW = 0; MIDELEG_REGW = 0; MEDELEG_REGW = 0;
    MTVEC_REGW = 0; STVEC_REGW = 0;
  endtask

  task automatic rand_inputs();
    int p;
    reset              = ($urandom_range(39) == 0);
    StallM             = ($urandom_range(7) == 0);
    IllegalInstrFaultM = ($urandom_range(9) == 0);
    BreakpointFaultM   = ($urandom_range(11) == 0);
    EcallFaultM        = ($urandom_range(9) == 0);
    mretM              = ($urandom_range(5) == 0);
    sretM              = ($urandom_range(7) == 0);
    wfiM               = ($urandom_range(3) == 0);
    p                  = $urandom_range(2);
    PrivilegeModeW     = (p == 2) ? 2'd3 : 2'(p);
    STATUS_MIE         = 1'($urandom);
    STATUS_SIE         = 1'($urandom);
    MIP_REGW           = ($urandom_range(2) == 0) ? 12'($urandom) : 12'd0;
    MIE_REGW           = 12'($urandom);
    MIDELEG_REGW       = 12'($urandom);
    MEDELEG_REGW       = 16'($urandom);
    MTVEC_REGW         = {32'($urandom), 32'($urandom)};
    STVEC_REGW         = {32'($urandom), 32'($urandom)};
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    cyc();
    cyc();
    reset = 0;

    // Interrupt beats a same-cycle exception.
    STATUS_MIE = 1; MIP_REGW = 12'h888; MIE_REGW = 12'h888;
    cyc();
    IllegalInstrFaultM = 1;
    cyc_check();
    check_eq("prio_trap", 64'(TrapM), 64'd1);
    check_eq("prio_int", 64'(InterruptM), 64'd1);
    check_eq("prio_cause", 64'(CauseM), 64'd11);
    check_eq("prio_tos", 64'(TrapToSM), 64'd0);
    cyc_end();
    clear_inputs();
    cyc(); cyc();

    // Ecall from U delegated to S.
    PrivilegeModeW = 2'd0; EcallFaultM = 1; MEDELEG_REGW = 16'h0100;
    STVEC_REGW = 64'h8000_0101;
    cyc_check();
    check_eq("ecall_cause", 64'(CauseM), 64'd8);
    check_eq("ecall_tos", 64'(TrapToSM), 64'd1);
    check_eq("ecall_vec", TrapVectorM, 64'h8000_0100);
    cyc_end();
    clear_inputs();
    cyc();

    // Machine timer interrupt with vectored-mode tvec.
    STATUS_MIE = 1; MTVEC_REGW = 64'h1001; MIP_REGW = 12'h080; MIE_REGW = 12'h080;
    cyc();
    cyc_check();
    check_eq("vec_cause", 64'(CauseM), 64'd7);
`ifdef TRAP_VECTORED_EN
    check_eq("vec_pc", TrapVectorM, 64'h101C);
`else
    check_eq("vec_pc", TrapVectorM, 64'h1000);
`endif
    cyc_end();
    clear_inputs();
    cyc(); cyc();

    // WFI entry, then wake on a globally disabled pending interrupt.
    wfiM = 1;
    cyc_check();
    check_eq("wfi_enter_now", 64'(WFIStallM), 64'd0);
    cyc_end();
    wfiM = 0;
    cyc_check();
    check_eq("wfi_stalled", 64'(WFIStallM), 64'd1);
    cyc_end();
    MIP_REGW = 12'h080; MIE_REGW = 12'h080;
    cyc();
    cyc_check();
    check_eq("wfi_wake_stall", 64'(WFIStallM), 64'd1);
    cyc_end();
    cyc_check();
    check_eq("wfi_run", 64'(WFIStallM), 64'd0);
    check_eq("wfi_notrap", 64'(TrapM), 64'd0);
    cyc_end();
    clear_inputs();
    cyc();

    // mret loses to a pending enabled MSI.
    STATUS_MIE = 1; MIP_REGW = 12'h008; MIE_REGW = 12'h008;
    cyc();
    mretM = 1;
    cyc_check();
    check_eq("ret_trap", 64'(TrapM), 64'd1);
    check_eq("ret_cause", 64'(CauseM), 64'd3);
    check_eq("ret_suppressed", 64'(RetM), 64'd0);
    cyc_end();
    clear_inputs();
    cyc(); cyc();

    // Reset while sleeping in WFI.
    wfiM = 1;
    cyc();
    wfiM = 0;
    cyc_check();
    check_eq("rst_wfi_pre", 64'(WFIStallM), 64'd1);
    cyc_end();
    reset = 1; IllegalInstrFaultM = 1; mretM = 1;
    cyc_check();
    check_eq("rst_trap", 64'(TrapM), 64'd0);
    check_eq("rst_ret", 64'(RetM), 64'd0);
    check_eq("rst_stall", 64'(WFIStallM), 64'd0);
    cyc_end();
    reset = 0; IllegalInstrFaultM = 0; mretM = 0;
    cyc_check();
    check_eq("rst_run", 64'(WFIStallM), 64'd0);
    cyc_end();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
